qpu_event_queue: RTL and testbench

QPU_EVENT_QUEUE -- requirements
Module: qpu_event_queue

---
 rtl/qpu_event_queue_pkg.sv | 31 +++
 rtl/qpu_event_fifo.sv | 57 +++++
 rtl/qpu_event_queue.sv | 120 ++++++++++++
 tb/tb_qpu_event_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qpu_event_queue_pkg.sv
// Shared defaults and head-of-queue classification for the timed event queue.
// No logic of its own.
package qpu_event_queue_pkg;

  localparam int QPU_EVENT_NUM        = 8;
  localparam int QPU_EVENT_DEPTH      = 8;
  localparam int QPU_TIME_WIDTH       = 32;
  localparam int QPU_EVENT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    HEAD_IDLE = 2'd0,
    HEAD_WAIT = 2'd1,
    HEAD_FIRE = 2'd2,
    HEAD_LATE = 2'd3
  } head_act_e;

  // diff_msb is the top bit of (now - head.ts); clear means the head is in the past half-range.
  function automatic head_act_e classify_head(input logic is_empty,
                                              input logic diff_zero,
                                              input logic diff_msb);
    head_act_e act;
    act = HEAD_IDLE;
    if (!is_empty) begin
      if (diff_zero)      act = HEAD_FIRE;
      else if (!diff_msb) act = HEAD_LATE;
      else                act = HEAD_WAIT;
    end
    return act;
  endfunction

endpackage

// File: rtl/qpu_event_fifo.sv
// Per-channel synchronous FIFO with combinational head peek and flush.
// Push visible at head one cycle later; full/empty derive from the registered count.
module qpu_event_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qpu_event_queue.sv
// Timestamped per-channel event queues: heads release when the timer matches, past heads drop as late.
// Release strobe one cycle after match; wr_ready follows the target channel's registered full flag.
module qpu_event_queue
  import qpu_event_queue_pkg::*;
#(
  parameter int CH_NUM = QPU_EVENT_NUM,
  parameter int DEPTH  = QPU_EVENT_DEPTH,
  parameter int TIME_W = QPU_TIME_WIDTH,
  parameter int DATA_W = QPU_EVENT_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick_en,
  input  logic                       time_clr,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(CH_NUM)-1:0]  wr_ch,
  input  logic [TIME_W-1:0]          wr_time,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [TIME_W-1:0]          time_o,
  output logic [CH_NUM-1:0]          ev_valid,
  output logic [CH_NUM*DATA_W-1:0]   ev_data,
  output logic [CH_NUM-1:0]          late_err,
  input  logic                       err_clr,
  output logic [CH_NUM-1:0]          empty
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int ENT_W = TIME_W + DATA_W;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_NUM);

  typedef struct packed {
    logic [TIME_W-1:0] ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [TIME_W-1:0]        time_q;
  logic [CH_NUM-1:0]        full;
  logic [CH_NUM-1:0]        push;
  logic [CH_NUM-1:0]        pop;
  logic [CH_NUM-1:0]        fire;
  logic [CH_NUM-1:0]        late;
  logic [ENT_W-1:0]         head_raw [CH_NUM];
  logic [CH_NUM*DATA_W-1:0] ev_data_nxt;
  logic                     wr_ch_ok;
  logic                     wr_fire;
  entry_t                   wr_ent;

  assign time_o   = time_q;
  assign wr_ch_ok = ({1'b0, wr_ch} < CH_LIM);
  assign wr_ready = !rst && !time_clr && !(wr_ch_ok && full[wr_ch]);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_ent   = '{ts: wr_time, data: wr_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           time_q <= '0;
    else if (time_clr) time_q <= '0;
    else if (tick_en)  time_q <= time_q + TIME_W'(1);
  end

  // Out-of-range channel writes are accepted but match no queue.
  always_comb begin
    push = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      push[c] = wr_fire && wr_ch_ok && (wr_ch == CH_W'(c));
    end
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    qpu_event_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (wr_ent),
      .pop       (pop[g]),
      .flush     (time_clr),
      .head      (head_raw[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  always_comb begin
    entry_t            h;
    logic [TIME_W-1:0] diff;
    head_act_e         act;
    h           = '0;
    diff        = '0;
    act         = HEAD_IDLE;
    fire        = '0;
    late        = '0;
    ev_data_nxt = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      h       = head_raw[c];
      diff    = time_q - h.ts;
      act     = classify_head(empty[c], diff == '0, diff[TIME_W-1]);
      fire[c] = (act == HEAD_FIRE);
      late[c] = (act == HEAD_LATE);
      if (fire[c] && !time_clr) ev_data_nxt[c*DATA_W +: DATA_W] = h.data;
    end
  end

  assign pop = fire | late;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid <= '0;
      ev_data  <= '0;
      late_err <= '0;
    end else begin
      ev_valid <= fire & ~{CH_NUM{time_clr}};
      ev_data  <= ev_data_nxt;
      late_err <= (late_err & ~{CH_NUM{err_clr}}) | late;
    end
  end

endmodule

// File: tb/tb_qpu_event_queue.sv
// Directed bench for qpu_event_queue with an 8-bit timer so wrap-around is reachable.
module tb_qpu_event_queue;

  localparam int CH = 8;
  localparam int DEP = 8;
  localparam int TW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            tick_en;
  logic            time_clr;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_ch;
  logic [TW-1:0]   wr_time;
  logic [DW-1:0]   wr_data;
  logic [TW-1:0]   time_o;
  logic [CH-1:0]   ev_valid;
  logic [CH*DW-1:0] ev_data;
  logic [CH-1:0]   late_err;
  logic            err_clr;
  logic [CH-1:0]   empty;

  int total = 0;
  int passed = 0;

  qpu_event_queue #(
    .CH_NUM (CH),
    .DEPTH  (DEP),
    .TIME_W (TW),
    .DATA_W (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .time_clr (time_clr),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_time  (wr_time),
    .wr_data  (wr_data),
    .time_o   (time_o),
    .ev_valid (ev_valid),
    .ev_data  (ev_data),
    .late_err (late_err),
    .err_clr  (err_clr),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_time(input logic [TW-1:0] t);
    int n;
    n = 0;
    while (time_o !== t && n < 400) begin
      step();
      n++;
    end
    if (time_o !== t) chk("timeout_time_o", 64'(time_o), 64'(t));
  endtask

  task automatic write(input logic [2:0] ch, input logic [TW-1:0] t, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_time  = t;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [CH-1:0] seen;
    rst = 1'b1; tick_en = 1'b0; time_clr = 1'b0; wr_valid = 1'b0;
    wr_ch = '0; wr_time = '0; wr_data = '0; err_clr = 1'b0;
    step(); step();

    // reset state
    chk("rst_time_o",   64'(time_o),   64'h0);
    chk("rst_ev_valid", 64'(ev_valid), 64'h0);
    chk("rst_ev_data",  ev_data,       64'h0);
    chk("rst_late_err", 64'(late_err), 64'h0);
    chk("rst_wr_ready", 64'(wr_ready), 64'h0);
    chk("rst_empty",    64'(empty),    64'hFF);

    // basic release: first write on the first cycle out of reset
    rst = 1'b0; tick_en = 1'b1;
    wr_valid = 1'b1; wr_ch = 3'd2; wr_time = 8'd10; wr_data = 8'h5A;
    #1;
    chk("first_wr_ready", 64'(wr_ready), 64'h1);
    step();
    wr_valid = 1'b0;
    chk("ch2_not_empty", 64'(empty[2]), 64'h0);
    wait_time(8'd10);
    chk("pre_release_ev", 64'(ev_valid), 64'h0);
    step();
    chk("release_ev_valid", 64'(ev_valid), 64'h04);
    chk("release_ev_data",  ev_data, 64'h0000_0000_005A_0000);
    chk("release_empty2",   64'(empty[2]), 64'h1);
    step();
    chk("strobe_one_cycle", 64'(ev_valid), 64'h0);
    chk("data_zero_idle",   ev_data, 64'h0);

    // late entry
    wait_time(8'd20);
    write(3'd0, 8'd15, 8'h33);
    step();
    chk("late_err_set",   64'(late_err), 64'h01);
    chk("late_no_strobe", 64'(ev_valid), 64'h0);
    chk("late_popped",    64'(empty[0]), 64'h1);
    step();
    chk("late_err_sticky", 64'(late_err), 64'h01);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("late_err_cleared", 64'(late_err), 64'h0);

    // parallel release on ch0 and ch7
    write(3'd0, 8'd40, 8'h11);
    write(3'd7, 8'd40, 8'h77);
    wait_time(8'd40);
    step();
    tick_en = 1'b0;
    chk("parallel_ev_valid", 64'(ev_valid), 64'h81);
    chk("parallel_ev_data",  ev_data, 64'h7700_0000_0000_0011);

    // fill ch1 with the timer held
    for (int i = 0; i < DEP; i++) write(3'd1, 8'd100, 8'(i));
    wr_valid = 1'b1; wr_ch = 3'd1; wr_time = 8'd100; wr_data = 8'hEE;
    #1;
    chk("full_ch1_not_ready", 64'(wr_ready), 64'h0);
    wr_ch = 3'd3;
    #1;
    chk("ch3_ready_while_ch1_full", 64'(wr_ready), 64'h1);
    step();
    wr_valid = 1'b0;
    chk("ch3_accepted", 64'(empty), 64'hF5);
    chk("no_late_on_future", 64'(late_err), 64'h0);

    // timer clear flushes all queues
    time_clr = 1'b1;
    #1;
    chk("clr_blocks_ready", 64'(wr_ready), 64'h0);
    step();
    time_clr = 1'b0;
    chk("clr_time_o",   64'(time_o),   64'h0);
    chk("clr_empty",    64'(empty),    64'hFF);
    chk("clr_ev_valid", 64'(ev_valid), 64'h0);

    // wrap-around: timestamp 3 written at time 250 waits for the wrap
    tick_en = 1'b1;
    wait_time(8'd250);
    write(3'd4, 8'd3, 8'hC3);
    wait_time(8'd3);
    step();
    chk("wrap_ev_valid", 64'(ev_valid), 64'h10);
    chk("wrap_ev_data",  ev_data, 64'h0000_00C3_0000_0000);
    chk("wrap_no_late",  64'(late_err), 64'h0);

    // asynchronous reset mid-run
    write(3'd5, 8'd50, 8'h55);
    write(3'd6, 8'd60, 8'h66);
    chk("queued_before_rst", 64'(empty), 64'h9F);
    rst = 1'b1;
    #1;
    chk("async_rst_time_o",   64'(time_o),   64'h0);
    chk("async_rst_empty",    64'(empty),    64'hFF);
    chk("async_rst_wr_ready", 64'(wr_ready), 64'h0);
    step();
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 80 && time_o != 8'd70; i++) begin
      step();
      seen |= ev_valid;
    end
    chk("no_strobe_after_rst", 64'(seen), 64'h0);
    chk("time_after_rst", 64'(time_o), 64'd70);

    // identical timestamps with the timer held, push and pop together
    tick_en = 1'b0;
    step();
    write(3'd2, 8'd70, 8'hA1);
    chk("dup_none_yet", 64'(ev_valid), 64'h0);
    write(3'd2, 8'd70, 8'hA2);
    chk("dup_first_valid", 64'(ev_valid), 64'h04);
    chk("dup_first_data",  64'(ev_data[23:16]), 64'hA1);
    chk("dup_still_queued", 64'(empty[2]), 64'h0);
    step();
    chk("dup_second_valid", 64'(ev_valid), 64'h04);
    chk("dup_second_data",  64'(ev_data[23:16]), 64'hA2);
    chk("dup_drained", 64'(empty[2]), 64'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
